// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream arbiter/multiplexer.
// rr_pick is the round-robin search used by stream_arb_mux in ARB_RR mode.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        ARB_SEL = 1'b0,
        ARB_RR  = 1'b1
    } arb_mode_e;

    typedef enum logic [0:0] {
        LOCK_OPEN = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Widest valid vector the round-robin search handles.
    localparam int unsigned RR_MAX = 32'd32;

    // First valid index at or after ptr, wrapping at n; ptr itself when nothing is valid.
    function automatic int unsigned rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int unsigned       ptr,
        input int unsigned       n
    );
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned j = 32'd0; j < RR_MAX; j++) begin
            idx = ptr + j;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if (!found && (j < n) && valid[idx[4:0]]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/stream_arb_mux_chk.sv
// Protocol checks for stream_arb_mux: parameter range, single ready,
// output stability under backpressure and lock integrity.
module stream_arb_mux_chk
    import stream_arb_pkg::*;
#(
    parameter type         DATA_T = logic,
    parameter int unsigned N_INP  = 32'd2,
    parameter int unsigned IDX_W  = 32'd1
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic [N_INP-1:0] inp_valid_i,
    input logic [N_INP-1:0] inp_ready_o,
    input DATA_T            oup_data_o,
    input logic [IDX_W-1:0] oup_idx_o,
    input logic             oup_valid_o,
    input logic             oup_ready_i,
    input logic             lock_held,
    input logic [IDX_W-1:0] lock_idx
);

    a_n_inp: assert property (@(posedge clk_i) (N_INP >= 32'd1) && (N_INP <= RR_MAX))
        else $error("stream_arb_mux: N_INP out of range");

    a_ready_onehot0: assert property (@(posedge clk_i) $onehot0(inp_ready_o))
        else $error("stream_arb_mux: more than one input ready");

    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (oup_valid_o && !oup_ready_i) |=>
            (oup_valid_o && $stable(oup_data_o) && $stable(oup_idx_o)))
        else $error("stream_arb_mux: output changed under backpressure");

    a_lock_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        lock_held |-> inp_valid_i[lock_idx])
        else $error("stream_arb_mux: locked input dropped valid");

endmodule

// File: rtl/stream_arb_slice.sv
// Two-entry register slice carrying a payload and its source index.
// Accepts a new beat whenever it is not full, so one entry absorbs the registered ready.
module stream_arb_slice
    import stream_arb_pkg::*;
#(
    parameter type         DATA_T = logic,
    parameter int unsigned IDX_W  = 32'd1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  DATA_T            in_data,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_valid,
    output logic             in_ready,
    output DATA_T            out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready
);

    DATA_T            data_r [2];
    logic [IDX_W-1:0] idx_r  [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       cnt_r;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (cnt_r != 2'd2);
    assign out_valid = (cnt_r != 2'd0);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;
    assign out_data  = data_r[rd_ptr_r];
    assign out_idx   = idx_r[rd_ptr_r];

    // Storage, pointers and occupancy of the two-entry FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_r[0] <= '0;
            data_r[1] <= '0;
            idx_r[0]  <= {IDX_W{1'b0}};
            idx_r[1]  <= {IDX_W{1'b0}};
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            cnt_r     <= 2'd0;
        end else begin
            if (push_s) begin
                data_r[wr_ptr_r] <= in_data;
                idx_r[wr_ptr_r]  <= in_idx;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// N-input valid/ready stream multiplexer with external or round-robin selection.
// The chosen input is locked while its beat waits, keeping the output AXI-stable.
module stream_arb_mux
    import stream_arb_pkg::*;
#(
    parameter type         DATA_T   = logic,
    parameter int unsigned N_INP    = 32'd2,
    parameter arb_mode_e   ARB_MODE = ARB_SEL,
    parameter bit          OUT_REG  = 1'b0,
    parameter int unsigned IDX_W    = (N_INP > 32'd1) ? $clog2(N_INP) : 32'd1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  DATA_T            inp_data_i [N_INP],
    input  logic [N_INP-1:0] inp_valid_i,
    output logic [N_INP-1:0] inp_ready_o,
    input  logic [IDX_W-1:0] inp_sel_i,
    output DATA_T            oup_data_o,
    output logic [IDX_W-1:0] oup_idx_o,
    output logic             oup_valid_o,
    input  logic             oup_ready_i
);

    lock_state_e      lock_state_r;
    logic [IDX_W-1:0] lock_idx_r;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] cand_s;
    logic [IDX_W-1:0] sel_s;
    logic             acc_s;
    logic             offer_valid_s;
    DATA_T            offer_data_s;
    logic             hs_s;

    // Candidate index from the external select or the round-robin search.
    always_comb begin
        cand_s = {IDX_W{1'b0}};
        if (N_INP == 32'd1) begin
            cand_s = {IDX_W{1'b0}};
        end else if (ARB_MODE == ARB_RR) begin
            cand_s = IDX_W'(rr_pick(RR_MAX'(inp_valid_i), 32'(rr_ptr_r), N_INP));
        end else begin
            cand_s = inp_sel_i;
        end
    end

    assign sel_s = (lock_state_r == LOCK_HELD) ? lock_idx_r : cand_s;

    // Route the selected input; an out-of-range select matches no input.
    always_comb begin
        offer_valid_s = 1'b0;
        offer_data_s  = inp_data_i[0];
        inp_ready_o   = {N_INP{1'b0}};
        for (int unsigned i = 32'd0; i < N_INP; i++) begin
            if (32'(sel_s) == i) begin
                offer_valid_s  = inp_valid_i[i] & ~rst_i;
                offer_data_s   = inp_data_i[i];
                inp_ready_o[i] = acc_s & ~rst_i;
            end else begin
                offer_valid_s  = offer_valid_s;
                offer_data_s   = offer_data_s;
                inp_ready_o[i] = 1'b0;
            end
        end
    end

    assign hs_s = offer_valid_s & acc_s;

    // Lock FSM: hold the selection from a stalled offer until its handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_state_r <= LOCK_OPEN;
            lock_idx_r   <= {IDX_W{1'b0}};
        end else begin
            case (lock_state_r)
                LOCK_OPEN: begin
                    if (offer_valid_s && !acc_s) begin
                        lock_state_r <= LOCK_HELD;
                        lock_idx_r   <= sel_s;
                    end
                end
                LOCK_HELD: begin
                    if (hs_s) begin
                        lock_state_r <= LOCK_OPEN;
                    end
                end
                default: begin
                    lock_state_r <= LOCK_OPEN;
                    lock_idx_r   <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Round-robin pointer moves past the winner after each handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if ((ARB_MODE == ARB_RR) && hs_s) begin
            rr_ptr_r <= (32'(sel_s) == (N_INP - 32'd1)) ? {IDX_W{1'b0}} : (sel_s + IDX_W'(1'b1));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    generate
        if (OUT_REG) begin : g_slice
            logic             slice_in_ready_s;
            logic             slice_valid_s;
            DATA_T            slice_data_s;
            logic [IDX_W-1:0] slice_idx_s;

            stream_arb_slice #(
                .DATA_T (DATA_T),
                .IDX_W  (IDX_W)
            ) u_slice (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .in_data   (offer_data_s),
                .in_idx    (sel_s),
                .in_valid  (offer_valid_s),
                .in_ready  (slice_in_ready_s),
                .out_data  (slice_data_s),
                .out_idx   (slice_idx_s),
                .out_valid (slice_valid_s),
                .out_ready (oup_ready_i)
            );

            assign acc_s       = slice_in_ready_s;
            assign oup_valid_o = slice_valid_s & ~rst_i;
            assign oup_data_o  = slice_data_s;
            assign oup_idx_o   = slice_idx_s;
        end else begin : g_comb
            assign acc_s       = oup_ready_i;
            assign oup_valid_o = offer_valid_s;
            assign oup_data_o  = offer_data_s;
            assign oup_idx_o   = sel_s;
        end
    endgenerate

    stream_arb_mux_chk #(
        .DATA_T (DATA_T),
        .N_INP  (N_INP),
        .IDX_W  (IDX_W)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inp_valid_i (inp_valid_i),
        .inp_ready_o (inp_ready_o),
        .oup_data_o  (oup_data_o),
        .oup_idx_o   (oup_idx_o),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .lock_held   (lock_state_r == LOCK_HELD),
        .lock_idx    (lock_idx_r)
    );

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: four configurations driven together, checked against
// a behavioural model of grant, lock, round-robin pointer and output queue.
module tb_stream_arb_mux;
    import stream_arb_pkg::*;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] pv   [NI];
    logic [7:0] pd   [NI][4];
    logic [1:0] psel [NI];
    logic       ordy [NI];
    logic [3:0] hsv  [NI];

    int cfg_n   [NI] = '{4, 3, 3, 3};
    bit cfg_rr  [NI] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit cfg_reg [NI] = '{1'b0, 1'b0, 1'b1, 1'b1};

    int         m_lock [NI];
    int         m_ptr  [NI];
    int         m_cnt  [NI];
    logic [7:0] m_qd   [NI][2];
    int         m_qi   [NI][2];

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] d0 [4];
    logic [7:0] d1 [3];
    logic [7:0] d2 [3];
    logic [7:0] d3 [3];
    logic [3:0] r0;
    logic [2:0] r1, r2, r3;
    logic [7:0] od0, od1, od2, od3;
    logic [1:0] oi0, oi1, oi2, oi3;
    logic       ov0, ov1, ov2, ov3;

    always_comb begin
        for (int i = 0; i < 4; i++) d0[i] = pd[0][i];
        for (int i = 0; i < 3; i++) begin
            d1[i] = pd[1][i];
            d2[i] = pd[2][i];
            d3[i] = pd[3][i];
        end
    end

    stream_arb_mux #(.DATA_T(logic [7:0]), .N_INP(4), .ARB_MODE(ARB_SEL), .OUT_REG(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .inp_data_i(d0), .inp_valid_i(pv[0]), .inp_ready_o(r0),
        .inp_sel_i(psel[0]), .oup_data_o(od0), .oup_idx_o(oi0), .oup_valid_o(ov0), .oup_ready_i(ordy[0]));
    stream_arb_mux #(.DATA_T(logic [7:0]), .N_INP(3), .ARB_MODE(ARB_RR), .OUT_REG(1'b0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .inp_data_i(d1), .inp_valid_i(pv[1][2:0]), .inp_ready_o(r1),
        .inp_sel_i(psel[1]), .oup_data_o(od1), .oup_idx_o(oi1), .oup_valid_o(ov1), .oup_ready_i(ordy[1]));
    stream_arb_mux #(.DATA_T(logic [7:0]), .N_INP(3), .ARB_MODE(ARB_RR), .OUT_REG(1'b1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .inp_data_i(d2), .inp_valid_i(pv[2][2:0]), .inp_ready_o(r2),
        .inp_sel_i(psel[2]), .oup_data_o(od2), .oup_idx_o(oi2), .oup_valid_o(ov2), .oup_ready_i(ordy[2]));
    stream_arb_mux #(.DATA_T(logic [7:0]), .N_INP(3), .ARB_MODE(ARB_SEL), .OUT_REG(1'b1)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .inp_data_i(d3), .inp_valid_i(pv[3][2:0]), .inp_ready_o(r3),
        .inp_sel_i(psel[3]), .oup_data_o(od3), .oup_idx_o(oi3), .oup_valid_o(ov3), .oup_ready_i(ordy[3]));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic get_out(input int k, output logic [3:0] rdy, output logic [7:0] dat,
                           output logic [1:0] idx, output logic vld);
        case (k)
            0:       begin rdy = r0;         dat = od0; idx = oi0; vld = ov0; end
            1:       begin rdy = {1'b0, r1}; dat = od1; idx = oi1; vld = ov1; end
            2:       begin rdy = {1'b0, r2}; dat = od2; idx = oi2; vld = ov2; end
            default: begin rdy = {1'b0, r3}; dat = od3; idx = oi3; vld = ov3; end
        endcase
    endtask

    // Model one cycle of instance k: check outputs, then advance the model state.
    task automatic model_eval(input int k);
        logic [3:0] rdy, exp_rdy;
        logic [7:0] dat;
        logic [1:0] idx;
        logic       vld;
        int         n, cand, s;
        bit         acc, valid, hs, pop;
        n = cfg_n[k];
        get_out(k, rdy, dat, idx, vld);
        hsv[k] = 4'b0;
        if (rst) begin
            check_eq($sformatf("k%0d rst ready", k), rdy, 0);
            check_eq($sformatf("k%0d rst valid", k), vld, 0);
            m_lock[k] = -1;
            m_ptr[k]  = 0;
            m_cnt[k]  = 0;
        end else begin
            acc = cfg_reg[k] ? (m_cnt[k] < 2) : ordy[k];
            if (cfg_rr[k]) begin
                cand = m_ptr[k];
                for (int j = n - 1; j >= 0; j--) begin
                    if (pv[k][(m_ptr[k] + j) % n]) cand = (m_ptr[k] + j) % n;
                end
            end else begin
                cand = psel[k];
            end
            s       = (m_lock[k] >= 0) ? m_lock[k] : cand;
            valid   = (s < n) && pv[k][s];
            exp_rdy = ((s < n) && acc) ? (4'b0001 << s) : 4'b0000;
            hs      = valid && acc;
            pop     = 1'b0;
            check_eq($sformatf("k%0d ready", k), rdy, exp_rdy);
            if (!cfg_reg[k]) begin
                check_eq($sformatf("k%0d valid", k), vld, valid);
                if (valid) begin
                    check_eq($sformatf("k%0d data", k), dat, pd[k][s]);
                    check_eq($sformatf("k%0d idx", k), idx, s);
                end
            end else begin
                check_eq($sformatf("k%0d valid", k), vld, m_cnt[k] > 0);
                if (m_cnt[k] > 0) begin
                    check_eq($sformatf("k%0d data", k), dat, m_qd[k][0]);
                    check_eq($sformatf("k%0d idx", k), idx, m_qi[k][0]);
                    pop = ordy[k];
                end
            end
            if (m_lock[k] >= 0) begin
                if (hs) m_lock[k] = -1;
            end else if (valid && !acc) begin
                m_lock[k] = s;
            end
            if (cfg_rr[k] && hs) m_ptr[k] = (s == n - 1) ? 0 : s + 1;
            if (pop) begin
                m_qd[k][0] = m_qd[k][1];
                m_qi[k][0] = m_qi[k][1];
                m_cnt[k]--;
            end
            if (cfg_reg[k] && hs) begin
                m_qd[k][m_cnt[k]] = pd[k][s];
                m_qi[k][m_cnt[k]] = s;
                m_cnt[k]++;
            end
            if (hs) hsv[k] = 4'b0001 << s;
        end
    endtask

    task automatic eval();
        #1;
        for (int k = 0; k < NI; k++) model_eval(k);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic retire();
        for (int k = 0; k < NI; k++) pv[k] = pv[k] & ~hsv[k];
    endtask

    // Sources hold a beat until its handshake, then may raise a fresh one.
    task automatic random_inputs();
        rst = ($urandom_range(0, 63) == 0);
        for (int k = 0; k < NI; k++) begin
            psel[k] = 2'($urandom_range(0, 3));
            ordy[k] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < cfg_n[k]; i++) begin
                if (!pv[k][i] && $urandom_range(0, 2) != 0) begin
                    pv[k][i] = 1'b1;
                    pd[k][i] = 8'($urandom);
                end
            end
        end
    endtask

    logic [2:0] rr_v [14] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                              3'b101, 3'b101, 3'b101, 3'b101, 3'b111, 3'b111, 3'b011, 3'b011};
    int         rr_e [14] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2, 0, 1, 0, 1};
    bit         rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            pv[k] = 4'b0; psel[k] = 2'd0; ordy[k] = 1'b0; hsv[k] = 4'b0;
            m_lock[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0;
            for (int i = 0; i < 4; i++) pd[k][i] = 8'h00;
        end
        @(negedge clk);
        eval(); tick();
        eval(); tick();
        rst = 1'b0;
        eval();
        check_eq("reg data after reset", od2, 8'h00);
        check_eq("reg idx after reset", oi2, 2'd0);
        tick();

        // Fixed select, zero latency.
        psel[0] = 2'd2; pv[0] = 4'b0100; pd[0][2] = 8'hA5; ordy[0] = 1'b1;
        eval();
        check_eq("sel2 data", od0, 8'hA5);
        check_eq("sel2 idx", oi0, 2'd2);
        check_eq("sel2 ready", r0, 4'b0100);
        tick(); retire();

        // Lock holds input 1 while the select moves to 3.
        psel[0] = 2'd1; pv[0] = 4'b1010; pd[0][1] = 8'h11; pd[0][3] = 8'h33; ordy[0] = 1'b0;
        eval(); tick(); retire();
        psel[0] = 2'd3;
        eval();
        check_eq("lock idx", oi0, 2'd1);
        check_eq("lock data", od0, 8'h11);
        tick(); retire();
        ordy[0] = 1'b1;
        eval();
        check_eq("lock release ready", r0, 4'b0010);
        tick(); retire();
        eval();
        check_eq("after lock idx", oi0, 2'd3);
        check_eq("after lock data", od0, 8'h33);
        tick(); retire();

        // Round-robin order, skipping and wrap.
        ordy[1] = 1'b1;
        for (int t = 0; t < 14; t++) begin
            pv[1] = {1'b0, rr_v[t]};
            eval();
            check_eq($sformatf("rr seq %0d", t), oi1, rr_e[t]);
            tick(); retire();
        end
        pv[1] = 4'b0;

        // Registered slice with backpressure, then reset while full and locked.
        pv[2] = 4'b0001; pd[2][0] = 8'h40;
        for (int t = 0; t < 7; t++) begin
            ordy[2] = rdy_pat[t];
            eval();
            if (t == 0) begin
                check_eq("slice first valid", ov2, 1'b0);
                check_eq("slice first ready", r2, 3'b001);
            end else if (t == 1) begin
                check_eq("slice first beat", od2, 8'h40);
            end else if (t == 2) begin
                check_eq("slice full ready", r2, 3'b000);
            end
            tick();
            if (hsv[2][0]) pd[2][0] = pd[2][0] + 8'h01;
        end
        rst = 1'b1;
        eval();
        check_eq("mid reset valid", ov2, 1'b0);
        check_eq("mid reset ready", r2, 3'b000);
        tick();
        rst = 1'b0; pv[2] = 4'b0; ordy[2] = 1'b1;
        pv[1] = 4'b0101; ordy[1] = 1'b1;
        eval();
        check_eq("no stale beat", ov2, 1'b0);
        check_eq("rr ptr reset", oi1, 2'd0);
        tick(); retire();
        eval(); tick(); retire();

        for (int c = 0; c < 3000; c++) begin
            random_inputs();
            eval();
            tick();
            retire();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_arb_mux.md
Name: stream_arb_mux

Overview:
- Parametrised successor to the plain combinational stream multiplexer.
- Merges N_INP valid/ready streams into one output stream.
- Input selection is either externally driven (select mode) or internal round-robin (arbitration mode).
- Selection is locked while a transfer is pending, so the output is AXI-stable. An optional two-entry register slice cuts all combinational paths.
- Used in front of shared PLIC/interconnect resources where several requesters contend for one sink.

Parameters:
- DATA_T, logic, payload type.
- N_INP, 2, number of input streams; must be >= 1.
- ARB_MODE, stream_arb_pkg::ARB_SEL, ARB_SEL = use inp_sel_i; ARB_RR = round-robin.
- OUT_REG, 1'b0, 1 = two-entry registered output slice; 0 = combinational data path (lock and pointer logic still present).
- IDX_W, max(1,$clog2(N_INP)), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- inp_data_i  in  N_INP x DATA_T  input payloads
- inp_valid_i  in  N_INP  input valids
- inp_ready_o  out  N_INP  input readies; at most one bit high
- inp_sel_i  in  IDX_W  external select; ignored in ARB_RR
- oup_data_o  out  DATA_T  output payload
- oup_idx_o  out  IDX_W  index of the source of the current output beat
- oup_valid_o  out  1  output valid
- oup_ready_i  in  1  output ready

Behaviour:
- **Reset values** (rst_i high at clock edge):
  - lock cleared, rr_ptr=0, slice empty.
  - While rst_i is high: inp_ready_o='0, oup_valid_o=0.
  - With OUT_REG=1: oup_data_o='0, oup_idx_o=0.
- **Stage-accept signal "acc":**
  - OUT_REG=0: acc = oup_ready_i.
  - OUT_REG=1: acc = slice not full. Registered only; no combinational path from oup_ready_i.
- **Candidate index "cand":**
  - ARB_SEL: cand = inp_sel_i.
  - ARB_RR: cand = first i with inp_valid_i[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_INP. If none is valid, cand = rr_ptr.
- **Effective index "sel":** sel = lock_q ? lock_idx_q : cand.
- **Out-of-range select:** if sel >= N_INP (ARB_SEL, non-power-of-2 N_INP), then no input is selected, all readies are 0, and no beat is offered.
- **Offered beat:** valid = inp_valid_i[sel]; inp_ready_o[sel] = acc; all other ready bits are 0. Handshake hs = valid & acc.
- **Lock FSM (UNLOCKED / LOCKED):**
  - UNLOCKED → LOCKED when valid & !acc; lock_idx_q <= sel.
  - LOCKED → UNLOCKED on hs.
  - While LOCKED, changes on inp_sel_i or in the other valids have no effect.
  - If the locked input drops valid (protocol violation), the lock is held; an assertion fires.
- **RR pointer:** on hs in ARB_RR, rr_ptr <= (sel == N_INP-1) ? 0 : sel+1. The pointer is unchanged without a handshake. ARB_SEL does not use the pointer.
- **Output, OUT_REG=0:** oup_data_o = inp_data_i[sel], oup_idx_o = sel, oup_valid_o = valid. Zero latency.
- **Output, OUT_REG=1:**
  - Two-entry FIFO slice. Push on hs, pop on oup_valid_o & oup_ready_i. Simultaneous push and pop when full is not possible (acc=0); when it holds one entry, push and pop in the same cycle keeps count=1.
  - Latency 1 cycle; throughput 1 beat/cycle under continuous ready.
  - oup_data_o and oup_idx_o come from the head entry.
  - Data is stable while oup_valid_o & !oup_ready_i.
- **N_INP=1:** sel is always 0; behaves as a pass-through or register slice.
- **Reset mid-transfer:** lock, pointer and slice contents are discarded; no beat is emitted after reset.
- **Assertions:**
  - N_INP >= 1.
  - $onehot0(inp_ready_o).
  - Output stable under backpressure.
  - Locked input does not drop valid.

Decomposition:
- stream_arb_pkg holds:
  - arb_mode_e {ARB_SEL, ARB_RR}.
  - Function rr_pick(valid, ptr) returning the first-valid index from ptr with wrap.
- One sub-module, stream_arb_slice: two-entry register slice carrying {DATA_T, idx}. It uses clk_i/rst_i and exposes valid/ready both sides.
- Total RTL is roughly 200–300 lines.

Test Plan:
- ARB_SEL, N_INP=4, OUT_REG=0: sel=2, valid=4'b0100, data[2]=0xA5, oup_ready=1 → same cycle oup_data=0xA5, oup_idx=2, inp_ready=4'b0100.
- Lock: ARB_SEL, sel=1, valid[1]=1, oup_ready=0; inp_sel_i changes to 3 next cycle → oup_idx stays 1 and data unchanged until oup_ready=1. Then hs, and the following cycle sel=3 takes effect.
- ARB_RR, N_INP=3, all valid, oup_ready=1 for 6 cycles → oup_idx sequence 0,1,2,0,1,2. With valid=3'b101 → 0,2,0,2.
- ARB_RR wrap/skip: rr_ptr=2, valid=3'b011 → grant 0, then rr_ptr=1 → next grant 1.
- OUT_REG=1, continuous valid on input 0, oup_ready toggles 1,0,0,1,1 → first beat appears 1 cycle after input hs. inp_ready[0] drops only after 2 beats are buffered. No beat is lost or duplicated; order is preserved.
- Reset mid-operation: slice holding 2 beats and lock active; assert rst_i for one cycle → next cycle oup_valid_o=0, inp_ready_o=0 during reset, rr_ptr=0, no stale beat emitted afterwards.
